// File: rtl/mc_ctrl_seq.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with handshaked fetch and
// load/store requests, byte-strobe generation, misalignment detection and LSU timeout.
module mc_ctrl_seq #(
  parameter int DATA_BYTES  = 4,
  parameter int LSU_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          if_req,
  input  logic                          if_ack,
  output logic                          inst_we,
  input  logic [3:0]                    extop,
  input  logic [2:0]                    func3,
  input  logic [6:0]                    func7,
  input  logic                          is_ebreak,
  input  logic                          is_mret,
  input  logic [$clog2(DATA_BYTES)-1:0] addr_lo,
  output logic                          lsu_req,
  output logic                          lsu_wen,
  output logic [DATA_BYTES-1:0]         lsu_wstrb,
  input  logic                          lsu_ack,
  output logic [2:0]                    mem_readop,
  output logic                          reg_write,
  output logic                          pc_write,
  output logic                          csr_write,
  output logic                          misalign_err,
  output logic                          bus_err,
  output logic                          halted
);

  localparam int AW = $clog2(DATA_BYTES);
  localparam logic [TO_W-1:0] TO_LAST = (LSU_TIMEOUT == 0) ? TO_W'(0) : TO_W'(LSU_TIMEOUT - 1);

  localparam logic [3:0] EX_JALR  = 4'd0;
  localparam logic [3:0] EX_LOAD  = 4'd1;
  localparam logic [3:0] EX_IALU  = 4'd2;
  localparam logic [3:0] EX_SYS   = 4'd4;
  localparam logic [3:0] EX_STORE = 4'd5;
  localparam logic [3:0] EX_BRAN  = 4'd6;
  localparam logic [3:0] EX_JAL   = 4'd7;
  localparam logic [3:0] EX_LUI   = 4'd8;
  localparam logic [3:0] EX_AUIPC = 4'd9;
  localparam logic [3:0] EX_R     = 4'd10;

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR, S_HALT
  } state_t;

  state_t                state, nxt;
  logic [3:0]            ext_q;
  logic [2:0]            f3_q;
  logic [6:0]            f7_q;
  logic                  mret_q;
  logic [DATA_BYTES-1:0] strb_q;
  logic                  err_bus_q;
  logic [TO_W-1:0]       to_cnt;
  logic                  to_hit;
  logic                  unused_bits;

  function automatic logic is_legal(input logic [3:0] e);
    return (e == EX_JALR) || (e == EX_LOAD) || (e == EX_IALU) || (e == EX_SYS) ||
           (e == EX_STORE) || (e == EX_BRAN) || (e == EX_JAL) || (e == EX_LUI) ||
           (e == EX_AUIPC) || (e == EX_R);
  endfunction

  function automatic logic writes_reg(input logic [3:0] e);
    return (e == EX_JALR) || (e == EX_LOAD) || (e == EX_IALU) || (e == EX_SYS) ||
           (e == EX_JAL) || (e == EX_LUI) || (e == EX_AUIPC) || (e == EX_R);
  endfunction

  function automatic logic writes_pc(input logic [3:0] e);
    return (e == EX_JALR) || (e == EX_BRAN) || (e == EX_JAL);
  endfunction

  // Size is 1 << sz_log bytes; wide intermediate keeps the 8-byte mask from overflowing.
  function automatic logic [DATA_BYTES-1:0] byte_mask(input logic [1:0] sz_log,
                                                      input logic [AW-1:0] off);
    logic [15:0] base;
    base = (16'd1 << (5'd1 << sz_log)) - 16'd1;
    base = base << off;
    return base[DATA_BYTES-1:0];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz_log, input logic [AW-1:0] off);
    logic [3:0] sz;
    logic [3:0] off_w;
    sz    = 4'd1 << sz_log;
    off_w = 4'(off);
    return (sz > 4'(DATA_BYTES)) || ((off_w & (sz - 4'd1)) != 4'd0);
  endfunction

  assign to_hit      = (LSU_TIMEOUT != 0) && (to_cnt == TO_LAST);
  assign mem_readop  = f3_q;
  assign unused_bits = ^{f7_q, func7};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RST;
      ext_q     <= '0;
      f3_q      <= '0;
      f7_q      <= '0;
      mret_q    <= 1'b0;
      strb_q    <= '0;
      err_bus_q <= 1'b0;
      to_cnt    <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) begin
        ext_q  <= extop;
        f3_q   <= func3;
        f7_q   <= func7;
        mret_q <= is_mret;
      end
      if (state == S_EXEC) begin
        strb_q    <= byte_mask(f3_q[1:0], addr_lo);
        err_bus_q <= 1'b0;
      end
      // Ack has priority over an expiring timeout in the same cycle.
      if (state == S_MEM) begin
        if (lsu_ack || to_hit) to_cnt <= '0;
        else                   to_cnt <= to_cnt + TO_W'(1);
        if (!lsu_ack && to_hit) err_bus_q <= 1'b1;
      end
    end
  end

  always_comb begin
    nxt          = state;
    if_req       = 1'b0;
    inst_we      = 1'b0;
    lsu_req      = 1'b0;
    lsu_wen      = 1'b0;
    lsu_wstrb    = '0;
    reg_write    = 1'b0;
    pc_write     = 1'b0;
    csr_write    = 1'b0;
    misalign_err = 1'b0;
    bus_err      = 1'b0;
    halted       = 1'b0;
    case (state)
      S_RST: nxt = S_FETCH;
      S_FETCH: begin
        if_req = 1'b1;
        if (if_ack) begin
          inst_we = 1'b1;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_ebreak)            nxt = S_HALT;
        else if (!is_legal(extop)) nxt = S_WB;
        else                      nxt = S_EXEC;
      end
      S_EXEC: begin
        if ((ext_q == EX_LOAD) || (ext_q == EX_STORE))
          nxt = is_misaligned(f3_q[1:0], addr_lo) ? S_ERR : S_MEM;
        else
          nxt = S_WB;
      end
      S_MEM: begin
        lsu_req   = 1'b1;
        lsu_wen   = (ext_q == EX_STORE);
        lsu_wstrb = strb_q;
        if (lsu_ack)     nxt = S_WB;
        else if (to_hit) nxt = S_ERR;
      end
      S_WB: begin
        reg_write = writes_reg(ext_q);
        pc_write  = writes_pc(ext_q);
        csr_write = (ext_q == EX_SYS) && !mret_q;
        nxt       = S_FETCH;
      end
      S_ERR: begin
        misalign_err = !err_bus_q;
        bus_err      = err_bus_q;
        nxt          = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: nxt = S_RST;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Directed bench for mc_ctrl_seq: one 4-byte-bus and one 8-byte-bus instance, both with a
// 5-cycle LSU timeout; a vector table drives single instructions, hand sequences cover resets.
module tb_mc_ctrl_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, if_ack, is_ebreak, is_mret, lsu_ack, sel;
  logic [3:0] extop;
  logic [2:0] func3;
  logic [6:0] func7;
  logic [1:0] addr4;
  logic [2:0] addr8;

  logic       if_req_a, inst_we_a, lsu_req_a, lsu_wen_a, reg_write_a, pc_write_a;
  logic       csr_write_a, misalign_err_a, bus_err_a, halted_a;
  logic [3:0] lsu_wstrb_a;
  logic [2:0] mem_readop_a;
  logic       if_req_b, inst_we_b, lsu_req_b, lsu_wen_b, reg_write_b, pc_write_b;
  logic       csr_write_b, misalign_err_b, bus_err_b, halted_b;
  logic [7:0] lsu_wstrb_b;
  logic [2:0] mem_readop_b;

  mc_ctrl_seq #(.DATA_BYTES(4), .LSU_TIMEOUT(5), .TO_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .if_req(if_req_a), .if_ack(if_ack), .inst_we(inst_we_a),
    .extop(extop), .func3(func3), .func7(func7), .is_ebreak(is_ebreak), .is_mret(is_mret),
    .addr_lo(addr4), .lsu_req(lsu_req_a), .lsu_wen(lsu_wen_a), .lsu_wstrb(lsu_wstrb_a),
    .lsu_ack(lsu_ack), .mem_readop(mem_readop_a), .reg_write(reg_write_a),
    .pc_write(pc_write_a), .csr_write(csr_write_a), .misalign_err(misalign_err_a),
    .bus_err(bus_err_a), .halted(halted_a));

  mc_ctrl_seq #(.DATA_BYTES(8), .LSU_TIMEOUT(5), .TO_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .if_req(if_req_b), .if_ack(if_ack), .inst_we(inst_we_b),
    .extop(extop), .func3(func3), .func7(func7), .is_ebreak(is_ebreak), .is_mret(is_mret),
    .addr_lo(addr8), .lsu_req(lsu_req_b), .lsu_wen(lsu_wen_b), .lsu_wstrb(lsu_wstrb_b),
    .lsu_ack(lsu_ack), .mem_readop(mem_readop_b), .reg_write(reg_write_b),
    .pc_write(pc_write_b), .csr_write(csr_write_b), .misalign_err(misalign_err_b),
    .bus_err(bus_err_b), .halted(halted_b));

  logic       o_if_req, o_inst_we, o_lsu_req, o_lsu_wen, o_rw, o_pw, o_cw, o_mis, o_bus, o_halt;
  logic [7:0] o_wstrb;
  logic [2:0] o_readop;
  logic [19:0] all_a;
  logic [23:0] all_b;

  assign o_if_req = sel ? if_req_b       : if_req_a;
  assign o_inst_we = sel ? inst_we_b     : inst_we_a;
  assign o_lsu_req = sel ? lsu_req_b     : lsu_req_a;
  assign o_lsu_wen = sel ? lsu_wen_b     : lsu_wen_a;
  assign o_rw      = sel ? reg_write_b   : reg_write_a;
  assign o_pw      = sel ? pc_write_b    : pc_write_a;
  assign o_cw      = sel ? csr_write_b   : csr_write_a;
  assign o_mis     = sel ? misalign_err_b : misalign_err_a;
  assign o_bus     = sel ? bus_err_b     : bus_err_a;
  assign o_halt    = sel ? halted_b      : halted_a;
  assign o_wstrb   = sel ? lsu_wstrb_b   : {4'b0000, lsu_wstrb_a};
  assign o_readop  = sel ? mem_readop_b  : mem_readop_a;
  assign all_a = {if_req_a, inst_we_a, lsu_req_a, lsu_wen_a, lsu_wstrb_a, mem_readop_a,
                  reg_write_a, pc_write_a, csr_write_a, misalign_err_a, bus_err_a, halted_a};
  assign all_b = {if_req_b, inst_we_b, lsu_req_b, lsu_wen_b, lsu_wstrb_b, mem_readop_b,
                  reg_write_b, pc_write_b, csr_write_b, misalign_err_b, bus_err_b, halted_b};

  typedef struct {
    int sel, extop, func3, func7, ebreak, mret, addr, fd, ack_at;
    int rw, pw, cw, mis, bus, req, wen, strb, halt, at;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    if_ack = 1'b0; lsu_ack = 1'b0; is_ebreak = 1'b0; is_mret = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_outs_a", int'(all_a), 0);
    chk("reset_outs_b", int'(all_b), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_if_req();
    int n;
    n = 0;
    while (!o_if_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("if_req", int'(o_if_req), 1);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int req_n, rw_n, pw_n, cw_n, mis_n, bus_n, rw_at, halt_at, wen_bad, strb_bad;
    bit back;
    v = vecs[idx];
    do_reset();
    sel = v.sel[0]; extop = 4'(v.extop); func3 = 3'(v.func3); func7 = 7'(v.func7);
    is_ebreak = v.ebreak[0]; is_mret = v.mret[0]; addr4 = 2'(v.addr); addr8 = 3'(v.addr);
    wait_if_req();
    repeat (v.fd) @(negedge clk);
    if_ack = 1'b1;
    #1;
    chk("inst_we", int'(o_inst_we), 1);
    @(negedge clk);
    if_ack = 1'b0;
    req_n = 0; rw_n = 0; pw_n = 0; cw_n = 0; mis_n = 0; bus_n = 0;
    rw_at = 0; halt_at = 0; wen_bad = 0; strb_bad = 0; back = 1'b0;
    for (int c = 1; c <= 25 && !back; c++) begin
      #1;
      if (o_if_req) back = 1'b1;
      else begin
        if (o_lsu_req) begin
          req_n++;
          if (int'(o_lsu_wen) != v.wen) wen_bad++;
          if (int'(o_wstrb) != v.strb) strb_bad++;
        end
        if (o_rw) begin rw_n++; rw_at = c; end
        if (o_pw) pw_n++;
        if (o_cw) cw_n++;
        if (o_mis) mis_n++;
        if (o_bus) bus_n++;
        if (o_halt && halt_at == 0) halt_at = c;
        lsu_ack = o_lsu_req && (v.ack_at != 0) && (req_n == v.ack_at);
        @(negedge clk);
        lsu_ack = 1'b0;
      end
    end
    chk($sformatf("v%0d_reg_write", idx), rw_n, v.rw);
    chk($sformatf("v%0d_pc_write", idx), pw_n, v.pw);
    chk($sformatf("v%0d_csr_write", idx), cw_n, v.cw);
    chk($sformatf("v%0d_misalign", idx), mis_n, v.mis);
    chk($sformatf("v%0d_bus_err", idx), bus_n, v.bus);
    chk($sformatf("v%0d_lsu_req_cycles", idx), req_n, v.req);
    chk($sformatf("v%0d_lsu_wen_bad", idx), wen_bad, 0);
    chk($sformatf("v%0d_lsu_wstrb_bad", idx), strb_bad, 0);
    chk($sformatf("v%0d_fetch_return", idx), int'(back), 1 - v.halt);
    chk($sformatf("v%0d_halted", idx), int'(o_halt), v.halt);
    chk($sformatf("v%0d_mem_readop", idx), int'(o_readop), v.func3);
    if (v.halt != 0) chk($sformatf("v%0d_halt_at", idx), halt_at, v.at);
    else if (v.at != 0) chk($sformatf("v%0d_wb_at", idx), rw_at, v.at);
  endtask

  initial begin
    rst_n = 1'b0; if_ack = 1'b0; lsu_ack = 1'b0; is_ebreak = 1'b0; is_mret = 1'b0;
    sel = 1'b0; extop = '0; func3 = '0; func7 = '0; addr4 = '0; addr8 = '0;

    //          sel ext f3 f7 eb mr ad fd ack  rw pw cw mis bus req wen strb halt at
    vecs[0]  = '{0, 2, 0, 0, 0, 0, 0, 3, 0,   1, 0, 0, 0, 0, 0, 0, 0,   0, 3};  // addi
    vecs[1]  = '{0, 5, 1, 0, 0, 0, 2, 0, 4,   0, 0, 0, 0, 0, 4, 1, 12,  0, 0};  // sh @2
    vecs[2]  = '{0, 1, 2, 0, 0, 0, 1, 1, 0,   0, 0, 0, 1, 0, 0, 0, 0,   0, 0};  // lw @1
    vecs[3]  = '{1, 1, 3, 0, 0, 0, 0, 0, 2,   1, 0, 0, 0, 0, 2, 0, 255, 0, 5};  // ld 8B
    vecs[4]  = '{0, 1, 2, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 5, 0, 15,  0, 0};  // timeout
    vecs[5]  = '{0, 1, 2, 0, 0, 0, 0, 0, 5,   1, 0, 0, 0, 0, 5, 0, 15,  0, 8};  // ack at 5
    vecs[6]  = '{0, 7, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 0, 0, 0,   0, 3};  // jal
    vecs[7]  = '{0, 4, 0, 24, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0,   0, 3};  // mret
    vecs[8]  = '{0, 4, 1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0, 0,   0, 3};  // csrrw
    vecs[9]  = '{0, 1, 3, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0,   0, 0};  // ld 4B
    vecs[10] = '{1, 1, 4, 0, 0, 0, 5, 0, 1,   1, 0, 0, 0, 0, 1, 0, 32,  0, 4};  // lbu @5
    vecs[11] = '{1, 5, 2, 0, 0, 0, 4, 2, 1,   0, 0, 0, 0, 0, 1, 1, 240, 0, 0};  // sw @4
    vecs[12] = '{0, 3, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0,   0, 0};  // illegal
    vecs[13] = '{0, 6, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0,   0, 0};  // branch
    vecs[14] = '{1, 8, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0,   0, 3};  // lui
    vecs[15] = '{0, 10, 0, 32, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 3};  // R-type
    vecs[16] = '{0, 5, 1, 0, 0, 0, 3, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0,   0, 0};  // sh @3
    vecs[17] = '{1, 5, 3, 0, 0, 0, 4, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0,   0, 0};  // sd @4
    vecs[18] = '{1, 1, 1, 0, 0, 0, 6, 0, 3,   1, 0, 0, 0, 0, 3, 0, 192, 0, 6};  // lh @6
    vecs[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0,   0, 3};  // jalr
    vecs[20] = '{0, 2, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0,   1, 2};  // ebreak

    for (int i = 0; i < NV; i++) run_vec(i);

    // halted instance: async reset clears everything immediately
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("halt_reset_outs_a", int'(all_a), 0);

    // reset while a fetch request is outstanding
    @(negedge clk);
    rst_n = 1'b1;
    sel = 1'b0; is_ebreak = 1'b0; extop = 4'd1; func3 = 3'd2; addr4 = 2'd0; addr8 = 3'd0;
    wait_if_req();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("fetch_reset_if_req", int'(if_req_a), 0);
    chk("fetch_reset_outs_a", int'(all_a), 0);

    // reset while a load waits for ack: request drops at once, no write pulse follows
    @(negedge clk);
    rst_n = 1'b1;
    wait_if_req();
    if_ack = 1'b1;
    @(negedge clk);
    if_ack = 1'b0;
    begin
      int n;
      n = 0;
      while (!lsu_req_a && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    chk("mem_lsu_req_seen", int'(lsu_req_a), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mem_reset_lsu_req", int'(lsu_req_a), 0);
    chk("mem_reset_outs_a", int'(all_a), 0);
    repeat (3) @(negedge clk);
    chk("mem_reset_no_wb", int'(reg_write_a | bus_err_a), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mc_ctrl_seq.md
Name: mc_ctrl_seq

Overview:
- Parametrised multi-cycle successor to the single-cycle control unit of the NPC core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives handshaked instruction-fetch and load/store requests, and generates byte strobes for a DATA_BYTES-wide data bus with misalignment detection.
- Applies an LSU response timeout and registers decoded control for the whole instruction.

Parameters:
- DATA_BYTES, 4, data bus width in bytes; legal values 4 or 8; AW = $clog2(DATA_BYTES).
- LSU_TIMEOUT, 255, cycles to wait for lsu_ack before bus error; 0 disables the timeout.
- TO_W, 8, timeout counter width; must satisfy LSU_TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  out  1  instruction fetch request; held until if_ack
- if_ack  in  1  fetch complete; instruction word valid this cycle
- inst_we  out  1  one-cycle pulse: external instruction register captures word
- extop  in  4  decoded class: 0 jalr, 1 load, 2 I-ALU, 4 system/CSR, 5 store, 6 branch, 7 jal, 8 lui, 9 auipc, 10 R; others illegal
- func3  in  3  instruction func3
- func7  in  7  instruction func7
- is_ebreak  in  1  decoded ebreak
- is_mret  in  1  decoded mret
- addr_lo  in  AW  low bits of effective address, valid in EXEC
- lsu_req  out  1  data access request; held until lsu_ack or timeout
- lsu_wen  out  1  1 = store, 0 = load; valid while lsu_req
- lsu_wstrb  out  DATA_BYTES  byte strobes, also used as load byte-enable
- lsu_ack  in  1  data access complete
- mem_readop  out  3  registered func3 for load extension
- reg_write  out  1  one-cycle WB pulse
- pc_write  out  1  one-cycle WB pulse for jal/jalr/branch
- csr_write  out  1  one-cycle WB pulse
- misalign_err  out  1  one-cycle pulse
- bus_err  out  1  one-cycle pulse
- halted  out  1  level; set on ebreak

Behaviour:
- Reset (async assert, sync release): state = RST; all outputs 0; timeout counter 0. First clock after release: RST -> FETCH.
- FETCH: if_req = 1. On if_ack: inst_we pulses in the same cycle, if_req drops, next state DECODE. if_ack while not in FETCH is ignored.
- DECODE, one cycle. Registers extop, func3, func7, is_ebreak, is_mret.
  - is_ebreak = 1 -> HALT.
  - Illegal extop -> WB with all write pulses suppressed.
  - Otherwise -> EXEC.
- EXEC, one cycle.
  - Access size = 1 << func3[1:0] bytes.
  - Misaligned when addr_lo mod size != 0, or size > DATA_BYTES (e.g. func3 = 3 with DATA_BYTES = 4).
  - Load/store: misaligned -> ERR, else latch strobe = ((1 << size) - 1) << addr_lo and go to MEM.
  - All other classes -> WB.
- MEM: lsu_req = 1, lsu_wen = (extop == 5), lsu_wstrb = latched strobe; all three held stable while waiting.
  - Counter increments each MEM cycle without ack.
  - lsu_ack -> WB; counter cleared.
  - LSU_TIMEOUT != 0 and counter == LSU_TIMEOUT - 1 without ack -> ERR with bus_err.
  - If ack and timeout coincide, ack wins.
- WB, one cycle, then -> FETCH.
  - reg_write = extop in {0, 1, 2, 4, 7, 8, 9, 10}.
  - pc_write = extop in {0, 6, 7}.
  - csr_write = (extop == 4) & ~is_mret.
- ERR, one cycle: pulses misalign_err or bus_err (exactly one); no reg/pc/csr write and no lsu_req; then -> FETCH.
- HALT: halted = 1, no requests issued. Only reset exits.
- Reset mid-MEM or mid-FETCH: request drops asynchronously and no write pulse is emitted. The bus must tolerate an abandoned request.
- mem_readop = registered func3; updates only in DECODE.

Test Plan:
- addi (extop = 2) with if_ack after 3 cycles -> inst_we in fetch-ack cycle; reg_write pulses exactly once, 3 cycles later (DECODE, EXEC, WB); no lsu_req.
- sh (extop = 5, func3 = 1), addr_lo = 2, DATA_BYTES = 4, lsu_ack after 4 cycles -> lsu_req 4 cycles, lsu_wen = 1, lsu_wstrb = 4'b1100, no reg_write.
- lw, addr_lo = 1 -> misalign_err one pulse, no lsu_req, next state FETCH. ld (func3 = 3) with DATA_BYTES = 8, addr_lo = 0 -> wstrb = 8'hFF.
- Load, lsu_ack never asserted, LSU_TIMEOUT = 5 -> lsu_req high exactly 5 cycles, then bus_err pulses; lsu_ack in cycle 5 instead -> WB and reg_write, no bus_err.
- ebreak -> halted = 1 after DECODE, if_req stays 0 for 20 cycles; rst_n low -> all outputs 0 immediately.
- jal (extop = 7) -> reg_write and pc_write both pulse in the same WB cycle. mret (extop = 4, is_mret = 1) -> reg_write = 1, csr_write = 0.
